// File: rtl/regfile_writeback.sv
// Register file write-port arbiter: ALU results bypass a small FIFO of
// long-latency results, and a pending scoreboard tracks in-flight registers.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [4:0]              lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [4:0]              check_rs1,
    input  logic [4:0]              check_rs2,
    output logic                    busy_rs1,
    output logic                    busy_rs2,
    output logic                    RegWrite,
    output logic [4:0]              rd,
    output logic [XLEN-1:0]         WriteData,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            src_lsu_q, src_lsu_d;
    logic [31:0]     pending_q, pending_d;

    logic push;
    logic pop;

    // Readiness uses start-of-cycle occupancy, so a full FIFO never accepts.
    assign lsu_ready = reset_n && (count_q < CW'(DEPTH));
    assign push      = lsu_valid && lsu_ready;
    assign pop       = !alu_valid && (count_q != '0);

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (push) begin
            rd_mem_d[wptr_q]   = lsu_rd;
            data_mem_d[wptr_q] = lsu_data;
            wptr_d             = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        src_lsu_d  = 1'b0;
        if (alu_valid) begin
            regwrite_d = (alu_rd != 5'd0);
            rd_d       = alu_rd;
            wdata_d    = alu_data;
        end else if (pop) begin
            regwrite_d = (rd_mem_q[rptr_q] != 5'd0);
            rd_d       = rd_mem_q[rptr_q];
            wdata_d    = data_mem_q[rptr_q];
            src_lsu_d  = 1'b1;
        end
    end

    // Clear on the commit edge first so a same-cycle issue re-marks the register.
    always_comb begin
        pending_d = pending_q;
        if (regwrite_q && src_lsu_q) begin
            pending_d[rd_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            src_lsu_q  <= 1'b0;
            pending_q  <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            src_lsu_q  <= src_lsu_d;
            pending_q  <= pending_d;
        end
    end

    assign busy_rs1   = (check_rs1 != 5'd0) && pending_q[check_rs1];
    assign busy_rs2   = (check_rs2 != 5'd0) && pending_q[check_rs2];
    assign RegWrite   = regwrite_q;
    assign rd         = rd_q;
    assign WriteData  = wdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: ALU vector table, scoreboard of expected
// register file writes, and directed multi-cycle sequences.
module tb_regfile_writeback;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  check_rs1;
    logic [4:0]  check_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WriteData;
    logic [2:0]  fifo_count;

    regfile_writeback #(.XLEN(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .check_rs1   (check_rs1),
        .check_rs2   (check_rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .WriteData   (WriteData),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
    } alu_vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Every committed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && reset_n && RegWrite) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                         rd, WriteData);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_rd", 32'(rd), 32'(e.rd));
                chk("wr_data", WriteData, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    alu_vec_t vec[6];

    initial begin
        vec[0] = '{5'd5,  32'hDEADBEEF, 1'b1};
        vec[1] = '{5'd0,  32'h12345678, 1'b0};
        vec[2] = '{5'd31, 32'hFFFFFFFF, 1'b1};
        vec[3] = '{5'd1,  32'h00000000, 1'b1};
        vec[4] = '{5'd0,  32'h0BADF00D, 1'b0};
        vec[5] = '{5'd17, 32'hA5A5A5A5, 1'b1};

        reset_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
        check_rs1 = 0; check_rs2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(lsu_ready), 0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(lsu_ready), 1);

        // ALU table, back to back
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) chk("alu_we", 32'(RegWrite), 32'(vec[i-1].exp_we));
            alu_valid = 1'b1;
            alu_rd    = vec[i].rd;
            alu_data  = vec[i].data;
            if (vec[i].exp_we) sb.push_back('{vec[i].rd, vec[i].data});
        end
        @(negedge clk);
        chk("alu_we_last", 32'(RegWrite), 32'(vec[5].exp_we));
        alu_valid = 1'b0;
        @(negedge clk);
        chk("idle_we", 32'(RegWrite), 0);
        chk("idle_rd_hold", 32'(rd), 17);
        chk("idle_data_hold", WriteData, 32'hA5A5A5A5);

        // Issue rd=7 at cycle 0, its result arrives at cycle 3
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7; check_rs1 = 5'd7;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            chk("busy7", 32'(busy_rs1), (c <= 5) ? 1 : 0);
            if (c == 3) begin
                lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
                sb.push_back('{5'd7, 32'h1234});
            end
            if (c == 4) begin
                lsu_valid = 1'b0;
                chk("lat_count", 32'(fifo_count), 1);
                chk("lat_we_c4", 32'(RegWrite), 0);
            end
            if (c == 5) chk("lat_we_c5", 32'(RegWrite), 1);
        end

        // Fill FIFO under a starving ALU stream (rd=0: no writes)
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            chk("fill_ready", 32'(lsu_ready), (k <= 4) ? 1 : 0);
            chk("fill_count", 32'(fifo_count), 32'(k - 1));
            lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'h100 + 32'(k);
            if (k <= 4) sb.push_back('{5'(k), 32'h100 + 32'(k)});
            @(negedge clk);
        end
        chk("no_5th", 32'(fifo_count), 4);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("drain_we", 32'(RegWrite), (j < 4) ? 1 : 0);
            chk("drain_count", 32'(fifo_count), (j < 4) ? 32'(3 - j) : 0);
            if (j == 0) chk("ready_back", 32'(lsu_ready), 1);
        end
        chk("drain_sb_empty", sb.size(), 0);

        // LSU entry with rd=0 is consumed silently
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBAD0BAD0;
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("rd0_count1", 32'(fifo_count), 1);
        @(negedge clk);
        chk("rd0_count0", 32'(fifo_count), 0);
        chk("rd0_we", 32'(RegWrite), 0);
        @(negedge clk);
        chk("rd0_we2", 32'(RegWrite), 0);

        // Re-issue of rd=9 on its own commit cycle keeps it pending
        issue_valid = 1'b1; issue_rd = 5'd9; check_rs1 = 5'd9; check_rs2 = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        sb.push_back('{5'd9, 32'h99});
        @(negedge clk);
        issue_valid = 1'b0; lsu_valid = 1'b0;
        chk("sw_busy_c1", 32'(busy_rs1), 1);
        chk("sw_rs2_clear", 32'(busy_rs2), 0);
        @(negedge clk);
        chk("sw_commit_we", 32'(RegWrite), 1);
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("set_wins", 32'(busy_rs1), 1);
        @(negedge clk);
        chk("set_wins_hold", 32'(busy_rs1), 1);

        // Asynchronous reset with 3 entries queued and registers pending
        mon_en = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA5A50001;
        issue_valid = 1'b1; issue_rd = 5'd12;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC12;
        @(negedge clk);
        issue_rd = 5'd13; lsu_rd = 5'd13; lsu_data = 32'hC13;
        @(negedge clk);
        issue_valid = 1'b0; lsu_rd = 5'd14; lsu_data = 32'hC14;
        @(negedge clk);
        lsu_valid = 1'b0;
        check_rs1 = 5'd12; check_rs2 = 5'd13;
        #1;
        chk("pre_rst_count", 32'(fifo_count), 3);
        chk("pre_rst_we", 32'(RegWrite), 1);
        chk("pre_rst_busy1", 32'(busy_rs1), 1);
        chk("pre_rst_busy2", 32'(busy_rs2), 1);
        #1;
        reset_n = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("arst_we", 32'(RegWrite), 0);
        chk("arst_rd", 32'(rd), 0);
        chk("arst_wdata", WriteData, 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_busy1", 32'(busy_rs1), 0);
        chk("arst_busy2", 32'(busy_rs2), 0);
        chk("arst_ready", 32'(lsu_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("post_rst_we", 32'(RegWrite), 0);
            chk("post_rst_count", 32'(fifo_count), 0);
        end
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
